spi_master_param: RTL
=====================

Name: spi_master_param

Overview:
Parametrised SPI master, next generation of the single-byte SPI master.
- Configurable word width, bit order and SCLK divider.
- Run-time selectable CPOL/CPHA, latched per transfer.
- Up to NUM_SS active-low slave selects.
- Start/busy/done handshake; sits between a register/CPU interface and external SPI slaves.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_SS, 4, number of slave-select outputs (power of 2, >=2)
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  transfer request, sampled only in IDLE
cpol  input  1  clock polarity, latched at start
cpha  input  1  clock phase, latched at start
ss_sel  input  $clog2(NUM_SS)  slave index, latched at start
tx_data  input  DATA_W  word to send, latched at start
miso  input  1  serial data from slave
mosi  output  1  serial data to slave
sclk  output  1  SPI clock
ss_n  output  NUM_SS  active-low slave selects, one-hot-low while busy
rx_data  output  DATA_W  last received word, held until next done
busy  output  1  high from cycle after start accept until done cycle inclusive
done  output  1  one-cycle pulse, rx_data valid in same cycle

Behaviour:
Reset values (async, immediate, including mid-transfer):
- state=IDLE; mosi=0; sclk=0; ss_n=all 1; rx_data=0; busy=0; done=0; shift and bit counters=0.

States: IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE.

- IDLE:
  - sclk <= cpol input every cycle.
  - start=1: latch tx_data/cpol/cpha/ss_sel, go to LEAD.
  - start is ignored in every other state.
- LEAD (CLK_DIV cycles):
  - ss_n[ss_sel]=0; sclk=latched cpol.
  - cpha=0: mosi = first bit at LEAD entry.
- XFER (2*DATA_W*CLK_DIV cycles):
  - Divider reaches CLK_DIV-1 -> sclk toggles (one edge); 2*DATA_W edges total.
  - cpha=0: sample miso on leading (odd) edges; drive next bit on trailing edges, except the final edge.
  - cpha=1: drive bit on leading edges; sample on trailing edges.
- TRAIL (CLK_DIV cycles):
  - sclk=latched cpol; ss_n held low; mosi held.
- DONE (1 cycle):
  - rx_data <= assembled word; done=1; busy=1; ss_n=all 1; mosi=0.
  - Next cycle IDLE, busy=0.

Latency and framing:
- start accepted at cycle 0 -> done at cycle 1+CLK_DIV*(2*DATA_W+2).
- Back-to-back: start high in the cycle after done is accepted. Minimum 2 idle SCLK-less cycles between frames.

Bit order:
- MSB_FIRST=1: transmit tx_data[DATA_W-1] first; received bits shift in at LSB.
- MSB_FIRST=0: transmit tx_data[0] first; received bits shift in at MSB.

Boundary conditions:
- cpol/cpha/tx_data/ss_sel changes while busy: no effect on the current transfer.
- CLK_DIV=1: sclk toggles every clk cycle, sclk frequency = clk/2.
- rst_n asserted mid-XFER: ss_n released immediately, rx_data returns to 0, no done pulse.

Optional Feature:
Macro SPI_MASTER_LOOPBACK_EN.
- Defined: extra input port loopback (1 bit). When loopback=1, the sampled serial-in is internal mosi instead of miso, and mosi, sclk and ss_n are held at idle values (0, cpol, all 1). Framing and timing are unchanged.
- Undefined: no loopback port; serial-in is always miso.

Test Plan:
- DATA_W=8, CLK_DIV=2, cpol=0, cpha=0, tx_data=0xA5, miso driven from a slave model returning 0x3C -> mosi bits 1,0,1,0,0,1,0,1; rx_data=0x3C; done at cycle 37 after start; exactly 16 sclk edges.
- Repeat with all four cpol/cpha modes, tx_data=0x81, slave returns 0x7E -> rx_data=0x7E each time; sclk idles at cpol before and after the frame.
- ss_sel=2, NUM_SS=4 -> ss_n=4'b1011 throughout LEAD..TRAIL, 4'b1111 in DONE and IDLE; start pulsed mid-transfer is ignored.
- DATA_W=16, MSB_FIRST=0, tx_data=0x0001 -> first mosi bit 1, then fifteen 0s; slave returns 0x8000 -> rx_data=0x8000.
- rst_n low at edge 5 of XFER -> same cycle: ss_n=all 1, busy=0, rx_data=0; no done pulse; a new start after release completes normally.
- SPI_MASTER_LOOPBACK_EN defined, loopback=1, tx_data=0x5A -> rx_data=0x5A; ss_n stays all 1; sclk stays at cpol.

Source files
------------

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module : spi_master_param
// Parametrised SPI master with per-transfer CPOL/CPHA and NUM_SS slave selects.
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input (mosi -> serial-in).
// Rev    : 1.0
// ============================================================================
module spi_master_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_SS    = 4,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic [$clog2(NUM_SS)-1:0] ss_sel,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                      loopback,
`endif
    output logic                      mosi,
    output logic                      sclk,
    output logic [NUM_SS-1:0]         ss_n,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned SEL_W  = $clog2(NUM_SS);
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W);

    localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] c_edge_last = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_XFER  = 3'd2,
        S_TRAIL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q,   div_d;
    logic [EDGE_W-1:0]   edge_q,  edge_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rx_q,    rx_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic                cpol_q,  cpol_d;
    logic                cpha_q,  cpha_d;
    logic                sclk_q,  sclk_d;
    logic                mosi_q,  mosi_d;

    logic                w_sin;
    logic                w_frame;
    logic [NUM_SS-1:0]   w_ss_n;

    // One shift register serves both directions: bits leave at one end while
    // received bits enter at the other, so after DATA_W shifts it holds rx.
    function automatic logic out_bit(input logic [DATA_W-1:0] s);
        return MSB_FIRST ? s[DATA_W-1] : s[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s,
                                                   input logic b);
        return MSB_FIRST ? {s[DATA_W-2:0], b} : {b, s[DATA_W-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            sel_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            sel_q   <= sel_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        sel_d   = sel_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;

        unique case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                div_d  = '0;
                edge_d = '0;
                if (start) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    sel_d   = ss_sel;
                    shift_d = tx_data;
                    state_d = S_LEAD;
                    if (!cpha) begin
                        mosi_d = out_bit(tx_data);
                    end
                end
            end
            S_LEAD: begin
                sclk_d = cpol_q;
                if (div_q == c_div_last) begin
                    div_d   = '0;
                    state_d = S_XFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_XFER: begin
                if (div_q == c_div_last) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    // edge_q even = leading edge of the bit period
                    if (!edge_q[0]) begin
                        if (cpha_q) mosi_d  = out_bit(shift_q);
                        else        shift_d = shift_in(shift_q, w_sin);
                    end else begin
                        if (cpha_q) begin
                            shift_d = shift_in(shift_q, w_sin);
                        end else if (edge_q != c_edge_last) begin
                            mosi_d = out_bit(shift_q);
                        end
                    end
                    if (edge_q == c_edge_last) begin
                        edge_d  = '0;
                        state_d = S_TRAIL;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_TRAIL: begin
                sclk_d = cpol_q;
                if (div_q == c_div_last) begin
                    div_d   = '0;
                    rx_d    = shift_q;
                    state_d = S_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                sclk_d  = cpol_q;
                mosi_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_frame = (state_q == S_LEAD) || (state_q == S_XFER) || (state_q == S_TRAIL);
    assign w_ss_n  = w_frame ? ~(NUM_SS'(1) << sel_q) : '1;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic w_idle_sclk;
    assign w_idle_sclk = (state_q == S_IDLE) ? sclk_q : cpol_q;
    assign w_sin = loopback ? mosi_q      : miso;
    assign mosi  = loopback ? 1'b0        : mosi_q;
    assign sclk  = loopback ? w_idle_sclk : sclk_q;
    assign ss_n  = loopback ? '1          : w_ss_n;
`else
    assign w_sin = miso;
    assign mosi  = mosi_q;
    assign sclk  = sclk_q;
    assign ss_n  = w_ss_n;
`endif

    assign rx_data = rx_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule
`default_nettype wire
